// File: rtl/dsp_buf_pkg.sv
// Shared types and sizing helpers for the DSP front-end frame buffers.
package dsp_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

    localparam int DEF_FRAME_LEN = 256;
    localparam int DEF_NUM_CH    = 2;
    localparam int RD_LATENCY    = 1;

    function automatic int smp_width(input int frame_len);
        return $clog2(frame_len);
    endfunction

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    localparam int SMP_W = smp_width(DEF_FRAME_LEN);
    localparam int CH_W  = ch_width(DEF_NUM_CH);

endpackage

// File: rtl/input_frame_buffer_if.sv
// Capture stream and frame read-port bundle between the sample source/engine and the buffer.
interface input_frame_buffer_if
    import dsp_buf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CH_BITS    = CH_W,
    parameter int SMP_BITS   = SMP_W
) ();
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  s_sof;
    logic                  frame_valid;
    logic                  frame_ack;
    logic [CH_BITS-1:0]    rd_ch;
    logic [SMP_BITS-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  frame_bank;

    modport master (
        output s_valid, s_data, s_sof, frame_ack, rd_ch, rd_addr,
        input  s_ready, frame_valid, frame_bank, rd_data
    );

    modport slave (
        input  s_valid, s_data, s_sof, frame_ack, rd_ch, rd_addr,
        output s_ready, frame_valid, frame_bank, rd_data
    );
endinterface

// File: rtl/frame_bank_ram.sv
// One capture bank: 1-write/1-read synchronous RAM with a resettable read register.
module frame_bank_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_W];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    assign rdata_d = mem_q[raddr];
    assign rdata   = rdata_q;

    // Array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= {DATA_WIDTH{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: rtl/input_frame_buffer.sv
// Ping-pong multi-channel capture buffer: fills one bank while the engine reads the other.
module input_frame_buffer
    import dsp_buf_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int FRAME_LEN    = DEF_FRAME_LEN,
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int DROP_ON_FULL = 0,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input_frame_buffer_if.slave  bus,
    output logic [CNT_WIDTH-1:0] overflow_cnt,
    output logic                 sync_err
);
    localparam int SB   = smp_width(FRAME_LEN);
    localparam int CB   = ch_width(NUM_CH);
    localparam int AB   = SB + CB;
    localparam bit DROP = (DROP_ON_FULL != 0);

    logic                 wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, rd_sel_q, rd_sel_d;
    logic [CB-1:0]        ch_idx_q, ch_idx_d, ch_eff_s;
    logic [SB-1:0]        smp_idx_q, smp_idx_d, smp_eff_s;
    bank_state_e          bank_st_q [2];
    bank_state_e          bank_st_d [2];
    logic                 frame_valid_q, frame_valid_d, s_ready_q, s_ready_d;
    logic                 sync_err_q, sync_err_d;
    logic [CNT_WIDTH-1:0] overflow_q, overflow_d;
    logic                 full_wr_s, wr_en_s, resync_s, drop_s;
    logic [AB-1:0]        ram_addr_s;
    logic [DATA_WIDTH-1:0] rdata_s [2];

    // Next-state for write indices, bank states, pointers and status.
    always_comb begin
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        rd_sel_d   = rd_bank_q;
        ch_idx_d   = ch_idx_q;
        smp_idx_d  = smp_idx_q;
        bank_st_d  = bank_st_q;
        sync_err_d = sync_err_q;
        overflow_d = overflow_q;

        full_wr_s = (bank_st_q[wr_bank_q] == FULL);
        wr_en_s   = bus.s_valid && s_ready_q && !full_wr_s;
        // A misplaced start-of-frame restarts the current bank at ch0/index0.
        resync_s  = wr_en_s && bus.s_sof &&
                    ((ch_idx_q != {CB{1'b0}}) || (smp_idx_q != {SB{1'b0}}));
        ch_eff_s  = resync_s ? {CB{1'b0}} : ch_idx_q;
        smp_eff_s = resync_s ? {SB{1'b0}} : smp_idx_q;
        ram_addr_s = {ch_eff_s, smp_eff_s};
        drop_s    = DROP && bus.s_valid && full_wr_s;

        if (wr_en_s) begin
            if (ch_eff_s == CB'(NUM_CH - 1)) begin
                ch_idx_d = {CB{1'b0}};
                if (smp_eff_s == SB'(FRAME_LEN - 1)) begin
                    smp_idx_d            = {SB{1'b0}};
                    bank_st_d[wr_bank_q] = FULL;
                    wr_bank_d            = !wr_bank_q;
                end else begin
                    smp_idx_d            = smp_eff_s + SB'(1);
                    bank_st_d[wr_bank_q] = FILLING;
                end
            end else begin
                ch_idx_d             = ch_eff_s + CB'(1);
                smp_idx_d            = smp_eff_s;
                bank_st_d[wr_bank_q] = FILLING;
            end
        end else begin
            ch_idx_d = ch_idx_q;
        end

        if (resync_s) begin
            sync_err_d = 1'b1;
        end else begin
            sync_err_d = sync_err_q;
        end

        if (drop_s && (overflow_q != {CNT_WIDTH{1'b1}})) begin
            overflow_d = overflow_q + CNT_WIDTH'(1);
        end else begin
            overflow_d = overflow_q;
        end

        if (bus.frame_ack && (bank_st_q[rd_bank_q] == FULL)) begin
            bank_st_d[rd_bank_q] = EMPTY;
            rd_bank_d            = !rd_bank_q;
        end else begin
            rd_bank_d = rd_bank_q;
        end

        frame_valid_d = (bank_st_d[rd_bank_d] == FULL);
        s_ready_d     = DROP ? 1'b1 : (bank_st_d[wr_bank_d] != FULL);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            rd_sel_q      <= 1'b0;
            ch_idx_q      <= {CB{1'b0}};
            smp_idx_q     <= {SB{1'b0}};
            bank_st_q[0]  <= EMPTY;
            bank_st_q[1]  <= EMPTY;
            frame_valid_q <= 1'b0;
            s_ready_q     <= 1'b1;
            sync_err_q    <= 1'b0;
            overflow_q    <= {CNT_WIDTH{1'b0}};
        end else begin
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            rd_sel_q      <= rd_sel_d;
            ch_idx_q      <= ch_idx_d;
            smp_idx_q     <= smp_idx_d;
            bank_st_q     <= bank_st_d;
            frame_valid_q <= frame_valid_d;
            s_ready_q     <= s_ready_d;
            sync_err_q    <= sync_err_d;
            overflow_q    <= overflow_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        frame_bank_ram #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_W    (AB)
        ) u_ram (
            .clk  (clk),
            .reset(reset),
            .we   (wr_en_s && (wr_bank_q == 1'(b))),
            .waddr(ram_addr_s),
            .wdata(bus.s_data),
            .raddr({bus.rd_ch, bus.rd_addr}),
            .rdata(rdata_s[b])
        );
    end

    assign bus.s_ready     = s_ready_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_bank  = rd_bank_q;
    assign bus.rd_data     = rd_sel_q ? rdata_s[1] : rdata_s[0];
    assign overflow_cnt    = overflow_q;
    assign sync_err        = sync_err_q;
endmodule

// File: tb/tb_input_frame_buffer.sv
// Directed scoreboard bench: dut0 backpressures (DROP_ON_FULL=0), dut1 drops (DROP_ON_FULL=1, 4-bit counter).
module tb_input_frame_buffer;
    import dsp_buf_pkg::*;

    localparam int DW = 16;
    localparam int FL = 4;
    localparam int NC = 2;

    typedef struct {
        int          d;
        logic [15:0] v;
        int          tag;
    } rexp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    logic        sv [2];
    logic        ssof [2];
    logic        ack [2];
    logic [15:0] sdat [2];
    logic [0:0]  rch [2];
    logic [1:0]  radr [2];
    logic        rdy [2];
    logic        fv [2];
    logic        fb [2];
    logic [15:0] rdat [2];
    logic [15:0] ovf0;
    logic [3:0]  ovf1;
    logic        se0, se1;
    logic        ren [2];
    logic        pend [2];
    rexp_t       q [$];
    int          total = 0;
    int          bad = 0;
    int          rd_tag = 0;

    input_frame_buffer_if #(.DATA_WIDTH(DW), .CH_BITS(1), .SMP_BITS(2)) bus0 ();
    input_frame_buffer_if #(.DATA_WIDTH(DW), .CH_BITS(1), .SMP_BITS(2)) bus1 ();

    assign bus0.s_valid = sv[0];   assign bus1.s_valid = sv[1];
    assign bus0.s_data = sdat[0];  assign bus1.s_data = sdat[1];
    assign bus0.s_sof = ssof[0];   assign bus1.s_sof = ssof[1];
    assign bus0.frame_ack = ack[0]; assign bus1.frame_ack = ack[1];
    assign bus0.rd_ch = rch[0];    assign bus1.rd_ch = rch[1];
    assign bus0.rd_addr = radr[0]; assign bus1.rd_addr = radr[1];
    assign rdy[0] = bus0.s_ready;  assign rdy[1] = bus1.s_ready;
    assign fv[0] = bus0.frame_valid; assign fv[1] = bus1.frame_valid;
    assign fb[0] = bus0.frame_bank;  assign fb[1] = bus1.frame_bank;
    assign rdat[0] = bus0.rd_data;   assign rdat[1] = bus1.rd_data;

    input_frame_buffer #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .NUM_CH(NC), .DROP_ON_FULL(0), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .reset(rst0), .bus(bus0.slave), .overflow_cnt(ovf0), .sync_err(se0));
    input_frame_buffer #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .NUM_CH(NC), .DROP_ON_FULL(1), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .reset(rst1), .bus(bus1.slave), .overflow_cnt(ovf1), .sync_err(se1));

    always @(posedge clk) begin
        pend[0] <= ren[0];
        pend[1] <= ren[1];
    end

    // Read-data monitor: pops the expected sample one cycle after each read request.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (pend[d]) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rd_unexpected dut%0d: got %0d, none expected", d, rdat[d]);
                end else begin
                    rexp_t e;
                    e = q.pop_front();
                    if (e.d != d || rdat[d] !== e.v) begin
                        bad++;
                        $display("FAIL rd#%0d dut%0d: got %0d expected %0d", e.tag, d, rdat[d], e.v);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input int val, input bit sof);
        bit acc;
        bit done;
        done = 1'b0;
        sv[d] = 1'b1;
        sdat[d] = 16'(val);
        ssof[d] = sof;
        for (int n = 0; n < 20 && !done; n++) begin
            acc = rdy[d];
            step();
            if (acc) done = 1'b1;
        end
        sv[d] = 1'b0;
        ssof[d] = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout dut%0d: got no accept for %0d", d, val);
        end
    endtask

    task automatic stream(input int d, input int first, input int n);
        for (int i = 0; i < n; i++) send(d, first + i, 1'b0);
    endtask

    task automatic ackp(input int d);
        ack[d] = 1'b1;
        step();
        ack[d] = 1'b0;
    endtask

    task automatic rd(input int d, input int ch, input int a, input int exp);
        rch[d] = 1'(ch);
        radr[d] = 2'(a);
        ren[d] = 1'b1;
        rd_tag++;
        q.push_back('{d, 16'(exp), rd_tag});
        step();
        ren[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            sv[d] = 1'b0; ssof[d] = 1'b0; ack[d] = 1'b0; sdat[d] = 16'd0;
            rch[d] = 1'b0; radr[d] = 2'd0; ren[d] = 1'b0;
        end
        rst0 = 1'b1; rst1 = 1'b1;
        step(); step();
        rst0 = 1'b0; rst1 = 1'b0;

        chk("rst_ready", rdy[0], 1); chk("rst_fv", fv[0], 0); chk("rst_fb", fb[0], 0);
        chk("rst_ovf", ovf0, 0); chk("rst_serr", se0, 0); chk("rst_rdata", rdat[0], 0);

        // First frame 1..8 into bank 0
        stream(0, 1, 7);
        chk("fv_before_last", fv[0], 0);
        send(0, 8, 1'b0);
        chk("fv_after_last", fv[0], 1); chk("fb_first", fb[0], 0);
        rd(0, 1, 2, 6);

        // Fill bank 1, then backpressure with both banks full
        stream(0, 9, 8);
        chk("ready_both_full", rdy[0], 0);
        sv[0] = 1'b1; sdat[0] = 16'd17;
        step(); step(); step();
        chk("ready_stall", rdy[0], 0);
        sv[0] = 1'b0;
        ackp(0);
        chk("ack_fb", fb[0], 1); chk("ack_ready", rdy[0], 1); chk("ack_fv", fv[0], 1);
        stream(0, 17, 8);
        chk("ready_full_again", rdy[0], 0);
        rd(0, 0, 0, 9); rd(0, 1, 2, 14);
        ackp(0);
        chk("ack2_fb", fb[0], 0);
        rd(0, 0, 3, 23); rd(0, 1, 3, 24);

        // Completion of bank 1 coincides with ack of bank 0
        stream(0, 101, 7);
        sv[0] = 1'b1; sdat[0] = 16'd108; ack[0] = 1'b1;
        step();
        sv[0] = 1'b0; ack[0] = 1'b0;
        chk("sim_fb", fb[0], 1); chk("sim_fv", fv[0], 1); chk("sim_bank0_free", rdy[0], 1);
        rd(0, 1, 3, 108); rd(0, 0, 0, 101);

        // Mid-frame reset
        stream(0, 51, 5);
        rst0 = 1'b1; step(); rst0 = 1'b0;
        chk("mrst_fv", fv[0], 0); chk("mrst_fb", fb[0], 0); chk("mrst_ovf", ovf0, 0);
        chk("mrst_ready", rdy[0], 1);
        stream(0, 201, 7);
        chk("mrst_fv_partial", fv[0], 0);
        send(0, 208, 1'b0);
        chk("mrst_fv_done", fv[0], 1); chk("mrst_fb_done", fb[0], 0);
        rd(0, 0, 0, 201); rd(0, 1, 3, 208);

        // Misplaced start-of-frame on the third sample of bank 1
        send(0, 31, 1'b0); send(0, 32, 1'b0);
        chk("sof_serr_before", se0, 0);
        send(0, 33, 1'b1);
        chk("sof_serr", se0, 1);
        stream(0, 34, 6);
        chk("sof_not_done", rdy[0], 1);
        send(0, 40, 1'b0);
        chk("sof_done", rdy[0], 0);
        ackp(0);
        chk("sof_fb", fb[0], 1);
        rd(0, 0, 0, 33); rd(0, 1, 0, 34); rd(0, 1, 3, 40);

        // Drop mode: 24 samples, no ack
        send(1, 1, 1'b1);
        chk("d_sof_first_ok", se1, 0);
        stream(1, 2, 15);
        chk("d_fv", fv[1], 1);
        send(1, 17, 1'b1);
        stream(1, 18, 7);
        chk("d_ready", rdy[1], 1); chk("d_ovf8", ovf1, 8); chk("d_serr_ignored", se1, 0);
        ackp(1);
        chk("d_fb", fb[1], 1); chk("d_fv_after_ack", fv[1], 1);
        rd(1, 0, 0, 9); rd(1, 1, 3, 16);
        stream(1, 41, 8);
        stream(1, 60, 10);
        chk("d_ovf_sat", ovf1, 15);
        rd(1, 1, 1, 12);

        repeat (RD_LATENCY + 1) step();
        chk("sb_drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/input_frame_buffer.md
Name: input_frame_buffer

Overview:
- Multi-channel ping-pong (double-buffered) capture buffer at the front of the DSP accelerator datapath.
- Accepts a channel-interleaved sample stream and assembles it into frames of FRAME_LEN samples per channel, alternating between two banks.
- Hands each completed frame to the downstream processing engine through a valid/ack handshake and a synchronous random-access read port.
- Capture continues into the other bank while the engine reads, so processing never blocks acquisition unless both banks are full.

Parameters:
- DATA_WIDTH, 16, sample width in bits.
- FRAME_LEN, 256, samples per channel per frame; power of 2, >= 2.
- NUM_CH, 2, interleaved channels; >= 1.
- DROP_ON_FULL, 0: 0 = backpressure via s_ready; 1 = s_ready tied high, samples arriving while full are discarded and counted.
- CNT_WIDTH, 16, width of the overflow counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_data  in  DATA_WIDTH  input sample, channel-interleaved ch0..ch(NUM_CH-1).
- s_ready  out  1  buffer can accept s_data this cycle.
- s_sof  in  1  sample is ch0 of a new frame (resync marker).
- frame_valid  out  1  a completed frame is available in the read bank.
- frame_ack  in  1  consumer has finished the frame; release the bank.
- rd_ch  in  max(1,$clog2(NUM_CH))  read channel select.
- rd_addr  in  $clog2(FRAME_LEN)  read sample index within the frame.
- rd_data  out  DATA_WIDTH  sample at [rd_bank][rd_ch][rd_addr], 1-cycle latency.
- frame_bank  out  1  bank currently presented to the reader.
- overflow_cnt  out  CNT_WIDTH  saturating count of dropped samples (DROP_ON_FULL=1 only; otherwise 0).
- sync_err  out  1  sticky flag: s_sof arrived at a non-ch0 position or mid-frame.

Behaviour:
- All state updates on posedge clk. reset has priority over all other inputs.
- Reset state: wr_bank=0, rd_bank=0, ch_idx=0, smp_idx=0, full[1:0]=0, frame_valid=0, overflow_cnt=0, sync_err=0, rd_data=0. Memory contents are not cleared.
- Write accept: accept = s_valid && s_ready.
  - s_ready = !full[wr_bank] when DROP_ON_FULL=0; constant 1 when DROP_ON_FULL=1.
- On accept, and when full[wr_bank]=0:
  - store s_data at [wr_bank][ch_idx][smp_idx].
  - ch_idx increments and wraps at NUM_CH; on wrap, smp_idx increments.
  - When ch_idx=NUM_CH-1 and smp_idx=FRAME_LEN-1: set full[wr_bank], toggle wr_bank, clear both indices.
- Drop: when DROP_ON_FULL=1 and s_valid=1 while full[wr_bank]=1, the sample is discarded, indices hold, and overflow_cnt increments, saturating at all-ones.
- Resync (s_sof):
  - Accepted s_sof with ch_idx=0 and smp_idx=0: normal write.
  - Accepted s_sof otherwise: set sync_err; discard the partial frame by resetting indices to 0; write the sample as ch0/index0 of the current wr_bank.
  - s_sof is ignored on dropped samples.
- Read side:
  - frame_valid = full[rd_bank]. frame_bank = rd_bank.
  - frame_ack while frame_valid=1 clears full[rd_bank] and toggles rd_bank next cycle.
  - frame_ack while frame_valid=0 is ignored.
- Simultaneous completion and ack on different banks: both take effect in the same cycle.
- Simultaneous completion and ack on the same bank cannot occur; full blocks writes to that bank.
- Completion-to-frame_valid latency: 1 cycle after the accepting edge.
- Read port: rd_data registered from the bank rd_bank held at the sampling edge. Data read while frame_valid=0 is don't-care.
- Both banks full: s_ready=0 (backpressure), or drops (DROP_ON_FULL=1). Capture resumes on the cycle after frame_ack.
- Mid-operation reset discards all frames and the partial frame; the first accepted sample after reset is ch0/index0 of bank 0.

Decomposition:
- Shared package dsp_buf_pkg holds:
  - bank-state typedef {EMPTY, FILLING, FULL}.
  - localparams for index widths: SMP_W = $clog2(FRAME_LEN), CH_W = max(1,$clog2(NUM_CH)).
  - one-cycle read latency constant.
- One sub-module, frame_bank_ram: a single-bank, NUM_CH*FRAME_LEN-deep, 1-write/1-read synchronous RAM, instantiated twice.
  - Write enable is gated per bank by wr_bank.
  - Read output is muxed by rd_bank.
- Top level holds the write-index counters, full flags, bank pointers, and overflow/sync logic.

Test Plan:
- FRAME_LEN=4, NUM_CH=2; stream values 1..8 continuously -> frame_valid rises 1 cycle after value 8 is accepted. Reading (ch1, addr 2) returns 6 one cycle later. frame_bank=0.
- Stream 24 samples with no frame_ack, DROP_ON_FULL=0 -> s_ready falls after sample 16. frame_ack then advances to bank 1, and s_ready returns the following cycle. Samples 17..24 land in bank 0.
- Same stimulus with DROP_ON_FULL=1 -> s_ready stays 1 and overflow_cnt=8. After frame_ack, bank 1 still holds 9..16.
- Assert s_sof on the 3rd sample of a frame -> sync_err=1, and that sample reads back at (ch0, addr0). The frame completes 7 samples later.
- frame_ack on the same cycle as bank-1 completion while bank 0 is full -> rd_bank=1, frame_valid stays 1, and full[0]=0.
- Assert reset for 1 cycle after 5 samples of a frame -> frame_valid=0 and overflow_cnt=0. The next 8 samples complete bank 0.
